// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, slice operation
// encodings, controller states and the op-code legality helper.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;

  typedef enum logic [1:0] {
    SL_AND  = 2'b00,
    SL_OR   = 2'b01,
    SL_ADD  = 2'b10,
    SL_LESS = 2'b11
  } slice_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_XOR: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_top.sv
// 1-bit ALU slice: optional operand inversion, then AND / OR / full-add / less
// select; carry out is always the full-adder carry of the inverted operands.
module alu_top
  import alu_pkg::*;
(
  input  logic      a_i,
  input  logic      b_i,
  input  logic      cin_i,
  input  logic      a_invert_i,
  input  logic      b_invert_i,
  input  logic      less_i,
  input  slice_op_e operation_i,
  output logic      result_o,
  output logic      cout_o
);

  logic a_s;
  logic b_s;

  assign a_s    = a_i ^ a_invert_i;
  assign b_s    = b_i ^ b_invert_i;
  assign cout_o = (a_s & b_s) | (a_s & cin_i) | (b_s & cin_i);

  always_comb begin
    case (operation_i)
      SL_AND:  result_o = a_s & b_s;
      SL_OR:   result_o = a_s | b_s;
      SL_ADD:  result_o = a_s ^ b_s ^ cin_i;
      SL_LESS: result_o = less_i;
      default: result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: one alu_top slice walks the operands LSB first, carry kept
// in a flop; SLT takes one extra cycle to fold the MSB sum and overflow.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             err
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [3:0]        op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d, cin_msb_q, cin_msb_d;
  logic              cout_msb_q, cout_msb_d, sum_msb_q, sum_msb_d;
  logic              busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;

  logic              legal_s, arith_s, bit_s;
  logic              sl_a_s, sl_b_s, sl_ainv_s, sl_binv_s, sl_res_s, sl_cout_s;
  slice_op_e         sl_op_s;

  assign legal_s = op_legal(op_q);
  assign arith_s = legal_s & op_q[1];

  // Illegal codes run the slice as AND on zeroed operands; SLT runs as SUB.
  always_comb begin
    sl_a_s    = legal_s ? a_q[idx_q] : 1'b0;
    sl_b_s    = legal_s ? b_q[idx_q] : 1'b0;
    sl_ainv_s = legal_s ? op_q[3] : 1'b0;
    sl_binv_s = legal_s ? op_q[2] : 1'b0;
    if (!legal_s) begin
      sl_op_s = SL_AND;
    end else if (op_q == OP_SLT) begin
      sl_op_s = SL_ADD;
    end else begin
      sl_op_s = slice_op_e'(op_q[1:0]);
    end
    bit_s = (op_q == OP_XOR) ? (a_q[idx_q] ^ b_q[idx_q]) : sl_res_s;
  end

  alu_top u_slice (
    .a_i         (sl_a_s),
    .b_i         (sl_b_s),
    .cin_i       (carry_q),
    .a_invert_i  (sl_ainv_s),
    .b_invert_i  (sl_binv_s),
    .less_i      (1'b0),
    .operation_i (sl_op_s),
    .result_o    (sl_res_s),
    .cout_o      (sl_cout_s)
  );

  // Next-state and datapath update for the serial controller.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    cin_msb_d  = cin_msb_q;
    cout_msb_d = cout_msb_q;
    sum_msb_d  = sum_msb_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = src1;
          b_d     = src2;
          op_d    = ALU_control;
          idx_d   = '0;
          acc_d   = '0;
          carry_d = (op_legal(ALU_control) & ALU_control[1]) ? ALU_control[2] : 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[idx_q] = bit_s;
        carry_d      = arith_s ? sl_cout_s : 1'b0;
        idx_d        = idx_q + IDXW'(1);
        if (idx_q == IDXW'(WIDTH - 1)) begin
          cin_msb_d  = carry_q;
          cout_msb_d = sl_cout_s;
          sum_msb_d  = sl_res_s;
          state_d    = (op_q == OP_SLT) ? FIX : DONE;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        // Signed less-than is the MSB sum corrected by signed overflow.
        acc_d   = {{(WIDTH-1){1'b0}}, sum_msb_q ^ (cin_msb_q ^ cout_msb_q)};
        state_d = DONE;
      end
      DONE: begin
        result_d = acc_q;
        zero_d   = (acc_q == '0);
        cout_d   = arith_s ? cout_msb_q : 1'b0;
        ovf_d    = arith_s ? (cin_msb_q ^ cout_msb_q) : 1'b0;
        err_d    = ~legal_s;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == FIX);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 4'b0000;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      sum_msb_q  <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      acc_q      <= acc_d;
      cin_msb_q  <= cin_msb_d;
      cout_msb_q <= cout_msb_d;
      sum_msb_q  <= sum_msb_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Bit-serial 32-bit ALU: drives one internal 1-bit ALU slice for one bit position per cycle, LSB first, and chains the carry through a flop.
- Accumulates a 32-bit result plus zero, carry-out and overflow flags.
- Sits between the operand source (register-read stage) and result writeback.
- Trades 32+ cycles of latency for single-slice area. Start/done handshake.

Parameters:
- WIDTH, 32, operand and result width (>=2).
- IDXW, 5, bit-index counter width (clog2 of WIDTH).

Ports:
- clk  in  1  single clock; all flops update on the rising edge.
- rst_n  in  1  synchronous reset, ACTIVE-HIGH despite the suffix (rst_n=1 resets on the next clk edge).
- start  in  1  request; sampled only in IDLE.
- src1  in  WIDTH  operand A; latched when start is accepted.
- src2  in  WIDTH  operand B; latched when start is accepted.
- ALU_control  in  4  op code; latched when start is accepted.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse when results are valid.
- result  out  WIDTH  final result; held until the next accepted start.
- zero  out  1  result == 0.
- cout  out  1  carry out of the MSB (arithmetic ops only, else 0).
- overflow  out  1  signed overflow (ADD/SUB/SLT only, else 0).
- err  out  1  illegal ALU_control was latched.

Behaviour:
- Reset: state=IDLE; busy, done, result, zero, cout, overflow, err=0; carry flop, bit index and latched operands cleared. Reset mid-operation aborts, with no done pulse.
- Op codes: ALU_control[3]=A_invert, [2]=B_invert, [1:0]=slice operation (00 AND, 01 OR, 10 ADD, 11 LESS).
  - Legal codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 XOR.
  - XOR is computed by the wrapper as a^b per bit, not by the slice.
- IDLE: when start=1, latch src1/src2/ALU_control, set idx=0, set carry=B_invert (1 for SUB/SLT), and go to RUN. When start=0, stay in IDLE.
- RUN: each cycle, drive the slice with a[idx], b[idx], carry.
  - For SLT, drive the slice as SUB (operation 10, B_invert=1); less=0.
  - Write the slice result into bit idx of the result accumulator. carry <= slice cout. idx <= idx+1.
  - At idx=WIDTH-1, record carry-in and carry-out of the MSB and the MSB sum.
  - Next state is FIX for SLT, else DONE.
- FIX (SLT only, 1 cycle): result <= {0..., sum_msb ^ overflow_msb}.
- DONE (1 cycle): done=1; update zero, cout, overflow and err; then return to IDLE.
  - cout and overflow = 0 for logic ops.
  - overflow = cin_msb ^ cout_msb.
- Latency: start accepted at edge E.
  - Non-SLT: done high in the cycle after edge E+WIDTH+1.
  - SLT: one cycle later.
- Handshake rules:
  - start is ignored while busy=1; no queuing.
  - start=1 during the DONE cycle is ignored; it is accepted once back in IDLE.
  - Outputs hold their values through IDLE until the next done.
- Illegal code: the block still runs WIDTH cycles with the slice operation forced to AND with a/b masked to 0. result=0, zero=1, err=1.
- Carry is arithmetic only: for logic ops the carry flop is held 0.

Decomposition:
- Package alu_pkg holds:
  - Op-code constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_XOR).
  - Slice operation encodings.
  - State enum IDLE/RUN/FIX/DONE.
  - WIDTH default.
- One sub-module: the existing 1-bit slice alu_top, instantiated once.
- The FSM, index counter, carry flop and result shift/accumulate logic live in alu_serial.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0, zero=0; done exactly WIDTH+2 cycles after the start edge.
- SUB 0x00000005 - 0x00000005 -> result 0, zero=1, cout=1, overflow=0. SUB 0 - 1 -> 0xFFFFFFFF, cout=0.
- SLT 0xFFFFFFFF vs 0x00000001 -> 1. SLT 0x7FFFFFFF vs 0x80000000 -> 0 (overflow-corrected). done one cycle later than ADD.
- Logic ops, a=0xF0F0F0F0, b=0xFF00FF00:
  - AND -> 0xF000F000
  - OR -> 0xFFF0FFF0
  - NOR -> 0x000F000F
  - XOR -> 0x0FF00FF0
  - cout=overflow=0 for all four.
- start pulsed again at cycle 10 of RUN with different operands -> ignored, first result unchanged. Illegal code 0011 -> result 0, err=1, zero=1.
- rst_n=1 at cycle 12 of RUN -> next cycle busy=0 and all outputs 0, no done. A new start afterwards completes correctly.
